// File: rtl/fp_pkg.sv
// Shared definitions for the double-precision datapath.
//
// Contents:
//   EXP_BIAS     : IEEE 754 double exponent bias
//   EXP_W        : biased exponent width
//   FRAC_W       : stored fraction width
//   MANT_W       : significand width including the hidden bit
//   INT_BIAS_TOP : biased exponent of bit 63 of a 64-bit integer (1023+63)
//   conv_state_t : state encoding for the integer-to-double converter
package fp_pkg;

    localparam int EXP_BIAS     = 1023;
    localparam int EXP_W        = 11;
    localparam int FRAC_W       = 52;
    localparam int MANT_W       = 53;
    localparam int INT_BIAS_TOP = 1086;

    typedef enum logic [1:0] {
        IDLE,
        NORMALIZE,
        ROUND,
        DONE
    } conv_state_t;

endpackage

// File: rtl/fp_rounder.sv
// Round-to-nearest-even incrementer used across the FP datapath.
//
// Ports:
//   mant_in   : significand before rounding (hidden bit included)
//   g, r, s   : guard, round and sticky bits below the significand LSB
//   mant_out  : rounded significand (wraps to zero on carry out)
//   carry_out : rounding overflowed the significand; caller bumps exponent
module fp_rounder
    import fp_pkg::*;
#(
    parameter int W = MANT_W
) (
    input  logic [W-1:0] mant_in,
    input  logic         g,
    input  logic         r,
    input  logic         s,
    output logic [W-1:0] mant_out,
    output logic         carry_out
);

    logic round_up;

    // Exact tie (g=1, r=s=0) only rounds up when the LSB is odd.
    assign round_up = g & (r | s | mant_in[0]);
    assign {carry_out, mant_out} = {1'b0, mant_in} + {{W{1'b0}}, round_up};

endmodule

// File: rtl/int64_to_fp.sv
// Multi-cycle 64-bit integer (signed or unsigned) to IEEE 754 double.
// The magnitude is normalized by iterative left shifts, then rounded RNE.
//
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   in_valid  : operand valid           in_ready  : converter idle, can accept
//   int_in    : integer operand         is_signed : int_in is two's complement
//   out_valid : result valid            out_ready : consumer accepts result
//   fp_out    : double result           inexact   : result was rounded
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for an operand, in_ready high
// NORMALIZE | shifting magnitude left until bit 63 is set
// ROUND     | RNE rounding to 53 bits, result registered
// DONE      | out_valid high, result held until out_ready
module int64_to_fp
    import fp_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] int_in,
    input  logic        is_signed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] fp_out,
    output logic        inexact
);

    localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(INT_BIAS_TOP);

    conv_state_t      state, state_nxt;
    logic             sign, sign_nxt;
    logic [63:0]      mag, mag_nxt;
    logic [EXP_W-1:0] exp_r, exp_nxt;
    logic [63:0]      fp_nxt;
    logic             inexact_nxt;

    logic [MANT_W-1:0] mant_rnd;
    logic              rnd_carry;
    logic              rnd_g, rnd_r, rnd_s;
    logic              unused_mant_msb;

    assign rnd_g = mag[10];
    assign rnd_r = mag[9];
    assign rnd_s = |mag[8:0];

    fp_rounder #(.W(MANT_W)) u_rounder (
        .mant_in   (mag[63:11]),
        .g         (rnd_g),
        .r         (rnd_r),
        .s         (rnd_s),
        .mant_out  (mant_rnd),
        .carry_out (rnd_carry)
    );

    // Hidden bit is implied; on carry the wrapped mantissa is already 1.0.
    assign unused_mant_msb = mant_rnd[MANT_W-1];

    assign in_ready  = (state == IDLE) & ~rst;
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sign    <= 1'b0;
            mag     <= '0;
            exp_r   <= '0;
            fp_out  <= '0;
            inexact <= 1'b0;
        end else begin
            state   <= state_nxt;
            sign    <= sign_nxt;
            mag     <= mag_nxt;
            exp_r   <= exp_nxt;
            fp_out  <= fp_nxt;
            inexact <= inexact_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        sign_nxt    = sign;
        mag_nxt     = mag;
        exp_nxt     = exp_r;
        fp_nxt      = fp_out;
        inexact_nxt = inexact;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    sign_nxt = is_signed & int_in[63];
                    // -2^63 negates to itself, which is the correct magnitude.
                    mag_nxt  = sign_nxt ? (~int_in + 64'd1) : int_in;
                    exp_nxt  = EXP_TOP;
                    if (mag_nxt == 64'd0) begin
                        fp_nxt      = 64'd0;
                        inexact_nxt = 1'b0;
                        state_nxt   = DONE;
                    end else begin
                        state_nxt = NORMALIZE;
                    end
                end
            end

            NORMALIZE: begin
                if (mag[63]) begin
                    state_nxt = ROUND;
                end else if (STEP == 4 && mag[63:60] == 4'b0000) begin
                    mag_nxt = {mag[59:0], 4'b0000};
                    exp_nxt = exp_r - EXP_W'(4);
                end else begin
                    mag_nxt = {mag[62:0], 1'b0};
                    exp_nxt = exp_r - EXP_W'(1);
                end
            end

            ROUND: begin
                // exp_r tops out at 1086, so the carry bump cannot overflow.
                fp_nxt      = {sign, exp_r + {{(EXP_W-1){1'b0}}, rnd_carry},
                               mant_rnd[FRAC_W-1:0]};
                inexact_nxt = rnd_g | rnd_r | rnd_s;
                state_nxt   = DONE;
            end

            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
